decode_issue: RTL and testbench



---
 rtl/decode_issue.sv | 185 ++++++++++++++++++
 tb/tb_decode_issue.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes 16-bit instructions, reads the internal register file,
// blocks RAW hazards with a per-register scoreboard and issues a registered bundle to the ALU.
// Optional build macro WB_BYPASS_EN forwards same-cycle writeback data into issue.
module decode_issue #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [DATA_W-1:0] out_store,
   output logic [3:0]        out_rd,
   output logic              out_wr_en,
   input  logic              wb_en,
   input  logic [3:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              halted
);

   typedef enum logic [1:0] {RUN, HALT_PEND, HALT} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  sb, sb_nxt, busy;

   logic [3:0]        opcode, rd, rs, rt;
   logic [DATA_W-1:0] rs_val, rt_val, rd_val;
   logic [DATA_W-1:0] imm4_sx, imm9_sx;
   logic [DATA_W-1:0] dec_op1, dec_op2, dec_store;
   logic              use_rs, use_rt, use_rd, writes, dec_wr_en;
   logic              wb_hit, hazard, accept, handoff;

   assign opcode  = in_instr[15:12];
   assign rd      = in_instr[11:8];
   assign rs      = in_instr[7:4];
   assign rt      = in_instr[3:0];
   assign imm4_sx = {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};
   assign imm9_sx = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
   assign wb_hit  = wb_en && (wb_addr != 4'd0);

   // R0 is never written, so its reset value of zero is what every read returns.
   always_comb begin
      rs_val = regs[rs];
      rt_val = regs[rt];
      rd_val = regs[rd];
      busy   = sb;
`ifdef WB_BYPASS_EN
      if (wb_hit) begin
         busy[wb_addr] = 1'b0;
         if (rs == wb_addr) rs_val = wb_data;
         if (rt == wb_addr) rt_val = wb_data;
         if (rd == wb_addr) rd_val = wb_data;
      end
`endif
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      use_rs    = 1'b0;
      use_rt    = 1'b0;
      use_rd    = 1'b0;
      writes    = 1'b0;
      dec_op1   = '0;
      dec_op2   = '0;
      dec_store = '0;
      case (opcode)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
            use_rs  = 1'b1;
            use_rt  = 1'b1;
            writes  = 1'b1;
            dec_op1 = rs_val;
            dec_op2 = rt_val;
         end
         4'h4, 4'h5, 4'h6: begin
            use_rs  = 1'b1;
            writes  = 1'b1;
            dec_op1 = rs_val;
            dec_op2 = DATA_W'(in_instr[3:0]);
         end
         4'h8, 4'h9: begin
            use_rs  = 1'b1;
            dec_op1 = rs_val;
            dec_op2 = {imm4_sx[DATA_W-2:0], 1'b0};
            if (opcode == 4'h9) begin
               use_rd    = 1'b1;
               dec_store = rd_val;
            end else begin
               writes = 1'b1;
            end
         end
         4'hA, 4'hB: begin
            use_rd  = 1'b1;
            writes  = 1'b1;
            dec_op1 = rd_val;
            dec_op2 = DATA_W'(in_instr[7:0]);
         end
         4'hC: dec_op2 = imm9_sx;
         4'hD: begin
            use_rs  = 1'b1;
            dec_op1 = rs_val;
         end
         4'hE:    writes = 1'b1;
         default: ;
      endcase
   end

   assign dec_wr_en = writes && (rd != 4'd0);
   assign hazard    = (use_rs && busy[rs]) || (use_rt && busy[rt]) || (use_rd && busy[rd]);
   assign in_ready  = (state == RUN) && !hazard && (!out_valid || out_ready) && !flush;
   assign accept    = in_valid && in_ready;
   assign handoff   = out_valid && out_ready;
   assign halted    = (state == HALT);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:       if (accept && opcode == 4'hF) state_nxt = HALT_PEND;
         HALT_PEND: if (flush) state_nxt = RUN;
                    else if (handoff) state_nxt = HALT;
         HALT:      ;
         default:   state_nxt = RUN;
      endcase
   end

   // Clears are applied before the set so a same-cycle issue to rd keeps its bit.
   always_comb begin
      sb_nxt = sb;
      if (wb_hit) sb_nxt[wb_addr] = 1'b0;
      if (flush && out_valid && out_wr_en) sb_nxt[out_rd] = 1'b0;
      if (accept && dec_wr_en) sb_nxt[rd] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         sb    <= '0;
      end else begin
         state <= state_nxt;
         sb    <= sb_nxt;
      end
   end

   // NOTE: the register file must read as zero after reset, so it is a flop array with an explicit reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wb_hit) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_opcode <= '0;
         out_op1    <= '0;
         out_op2    <= '0;
         out_store  <= '0;
         out_rd     <= '0;
         out_wr_en  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_opcode <= opcode;
         out_op1    <= dec_op1;
         out_op2    <= dec_op2;
         out_store  <= dec_store;
         out_rd     <= rd;
         out_wr_en  <= dec_wr_en;
      end else if (handoff) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios plus a randomized run
// against a transaction-level reference model of the issue stage.
module tb_decode_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid, in_ready, out_valid, out_ready, out_wr_en;
   logic        wb_en, flush, halted;
   logic [15:0] in_instr, out_op1, out_op2, out_store, wb_data;
   logic [3:0]  out_opcode, out_rd, wb_addr;

   typedef struct packed {
      logic        valid;
      logic [3:0]  opcode;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] store;
      logic [3:0]  rd;
      logic        wr_en;
   } bundle_t;

   bundle_t obs;
   assign obs = {out_valid, out_opcode, out_op1, out_op2, out_store, out_rd, out_wr_en};

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic [15:0] m_regs [16];
   bit          m_pend [16];
   bundle_t     m_out;
   int          m_mode;
   logic [3:0]  wbq [$];

   decode_issue #(.DATA_W(16), .NREGS(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_op1(out_op1), .out_op2(out_op2), .out_store(out_store),
      .out_rd(out_rd), .out_wr_en(out_wr_en),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic bundle_t mk(logic [3:0] op, logic [15:0] a, logic [15:0] b,
                                  logic [15:0] s, logic [3:0] rd, logic wr);
      return {1'b1, op, a, b, s, rd, wr};
   endfunction

   function automatic logic [15:0] m_read(logic [3:0] a);
      if (a == 4'd0) return 16'h0;
`ifdef WB_BYPASS_EN
      if (wb_en && wb_addr == a) return wb_data;
`endif
      return m_regs[a];
   endfunction

   function automatic bit m_busy(logic [3:0] a);
`ifdef WB_BYPASS_EN
      if (wb_en && wb_addr == a && a != 4'd0) return 1'b0;
`endif
      return m_pend[a];
   endfunction

   function automatic bit m_stall(logic [15:0] ins);
      int op = int'(ins[15:12]);
      bit need_rs = (op <= 9) || (op == 13);
      bit need_rt = (op <= 3) || (op == 7);
      bit need_rd = (op >= 9) && (op <= 11);
      return (need_rs && m_busy(ins[7:4])) || (need_rt && m_busy(ins[3:0])) ||
             (need_rd && m_busy(ins[11:8]));
   endfunction

   function automatic bundle_t m_bundle(logic [15:0] ins);
      bundle_t b = '0;
      int op = int'(ins[15:12]);
      int sx4 = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
      int sx9 = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
      b.valid  = 1'b1;
      b.opcode = ins[15:12];
      b.rd     = ins[11:8];
      if (op <= 3 || op == 7) begin
         b.op1 = m_read(ins[7:4]); b.op2 = m_read(ins[3:0]); b.wr_en = 1'b1;
      end else if (op <= 6) begin
         b.op1 = m_read(ins[7:4]); b.op2 = 16'(ins[3:0]); b.wr_en = 1'b1;
      end else if (op <= 9) begin
         b.op1 = m_read(ins[7:4]); b.op2 = 16'(sx4 * 2);
         if (op == 9) b.store = m_read(ins[11:8]);
         else b.wr_en = 1'b1;
      end else if (op <= 11) begin
         b.op1 = m_read(ins[11:8]); b.op2 = 16'(ins[7:0]); b.wr_en = 1'b1;
      end else if (op == 12) begin
         b.op2 = 16'(sx9);
      end else if (op == 13) begin
         b.op1 = m_read(ins[7:4]);
      end else if (op == 14) begin
         b.wr_en = 1'b1;
      end
      if (b.rd == 4'd0) b.wr_en = 1'b0;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 0; in_instr = '0; out_ready = 0;
      wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
      wb_en = 1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 0;
   endtask

   task automatic test_reset();
      idle();
      @(negedge clk);
      rst_n = 0;
      #1;
      n_tests++;
      if (obs !== '0 || halted !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs: got %h/%b want 0/0", obs, halted);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || obs !== '0) begin
         n_fail++; $display("FAIL reset_release: got ready=%b %h want ready=1 0", in_ready, obs);
      end
   endtask

   task automatic test_raw_stall();
      int  stalls = 0;
      bit  accepted = 0;
      int  exp_stalls;
`ifdef WB_BYPASS_EN
      exp_stalls = 1;
`else
      exp_stalls = 2;
`endif
      do_reset();
      wb_write(4'd1, 16'h0005);
      wb_write(4'd2, 16'h0003);
      out_ready = 1; in_valid = 1; in_instr = 16'h0312;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL add_accept: got %b want 1", in_ready);
      end
      tick();
      n_tests++;
      if (obs !== mk(4'h0, 16'h5, 16'h3, 16'h0, 4'h3, 1'b1)) begin
         n_fail++; $display("FAIL add_bundle: got %h want %h", obs, mk(4'h0, 16'h5, 16'h3, 16'h0, 4'h3, 1'b1));
      end
      in_instr = 16'h1431;
      for (int c = 0; c < 8 && !accepted; c++) begin
         wb_en = (c == 1); wb_addr = 4'd3; wb_data = 16'h0008;
         #1;
         if (c == 1) begin
            n_tests++;
            if (out_valid !== 1'b0) begin
               n_fail++; $display("FAIL stall_no_issue: got out_valid=%b want 0", out_valid);
            end
         end
         if (in_ready) accepted = 1;
         else stalls++;
         tick();
      end
      wb_en = 0; in_valid = 0;
      n_tests++;
      if (!accepted || stalls != exp_stalls) begin
         n_fail++; $display("FAIL raw_stall_len: got %0d (accepted=%0d) want %0d", stalls, accepted, exp_stalls);
      end
      n_tests++;
      if (obs !== mk(4'h1, 16'h8, 16'h5, 16'h0, 4'h4, 1'b1)) begin
         n_fail++; $display("FAIL sub_bundle: got %h want %h", obs, mk(4'h1, 16'h8, 16'h5, 16'h0, 4'h4, 1'b1));
      end
   endtask

   task automatic test_immediates();
      logic [15:0] prog [6];
      bundle_t     expv [6];
      prog = '{16'h851F, 16'hA6A5, 16'h9211, 16'hC1FF, 16'h0012, 16'h0300};
      expv = '{mk(4'h8, 16'h0005, 16'hFFFE, 16'h0, 4'h5, 1'b1),
               mk(4'hA, 16'h1234, 16'h00A5, 16'h0, 4'h6, 1'b1),
               mk(4'h9, 16'h0005, 16'h0002, 16'h3, 4'h2, 1'b0),
               mk(4'hC, 16'h0000, 16'hFFFF, 16'h0, 4'h1, 1'b0),
               mk(4'h0, 16'h0005, 16'h0003, 16'h0, 4'h0, 1'b0),
               mk(4'h0, 16'h0000, 16'h0000, 16'h0, 4'h3, 1'b1)};
      do_reset();
      wb_write(4'd1, 16'h0005);
      wb_write(4'd2, 16'h0003);
      wb_write(4'd6, 16'h1234);
      out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_instr = prog[i];
         #1;
         n_tests++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL imm_ready[%0d]: got %b want 1", i, in_ready);
         end
         tick();
         n_tests++;
         if (obs !== expv[i]) begin
            n_fail++; $display("FAIL imm_bundle[%0d]: got %h want %h", i, obs, expv[i]);
         end
      end
      in_valid = 0;
   endtask

   task automatic test_back_to_back();
      bundle_t exp_b;
      do_reset();
      wb_write(4'd1, 16'h0005);
      out_ready = 0; in_valid = 1; in_instr = 16'h4213;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_first: got %b want 1", in_ready);
      end
      tick();
      in_instr = 16'h4314;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (in_ready !== 1'b0 || obs !== mk(4'h4, 16'h5, 16'h3, 16'h0, 4'h2, 1'b1)) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got ready=%b %h want ready=0 %h", c, in_ready, obs,
                               mk(4'h4, 16'h5, 16'h3, 16'h0, 4'h2, 1'b1));
         end
         tick();
      end
      out_ready = 1;
      exp_b = mk(4'h4, 16'h5, 16'h4, 16'h0, 4'h3, 1'b1);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got %b want 1", in_ready);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         in_instr = {4'h4, 4'(4 + k), 4'h1, 4'(5 + k)};
         #1;
         n_tests++;
         if (in_ready !== 1'b1 || obs !== exp_b) begin
            n_fail++; $display("FAIL b2b[%0d]: got ready=%b %h want ready=1 %h", k, in_ready, obs, exp_b);
         end
         exp_b = mk(4'h4, 16'h5, 16'(5 + k), 16'h0, 4'(4 + k), 1'b1);
         tick();
      end
      in_valid = 0;
      n_tests++;
      if (obs !== exp_b) begin
         n_fail++; $display("FAIL b2b_last: got %h want %h", obs, exp_b);
      end
   endtask

   task automatic test_flush();
      do_reset();
      wb_write(4'd1, 16'h0005);
      wb_write(4'd2, 16'h0003);
      out_ready = 0; in_valid = 1; in_instr = 16'h0712;
      tick();
      flush = 1; in_instr = 16'h0871;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_no_accept: got %b want 0", in_ready);
      end
      tick();
      flush = 0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_drop: got %b want 0", out_valid);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_sb_clear: got ready=%b want 1", in_ready);
      end
      out_ready = 1;
      tick();
      in_valid = 0;
      n_tests++;
      if (obs !== mk(4'h0, 16'h0, 16'h5, 16'h0, 4'h8, 1'b1)) begin
         n_fail++; $display("FAIL flush_next: got %h want %h", obs, mk(4'h0, 16'h0, 16'h5, 16'h0, 4'h8, 1'b1));
      end
   endtask

   task automatic test_halt();
      do_reset();
      wb_write(4'd1, 16'h0005);
      out_ready = 0; in_valid = 1; in_instr = 16'hF000;
      tick();
      in_instr = 16'h4213;
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || halted !== 1'b0 || obs !== mk(4'hF, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0)) begin
         n_fail++; $display("FAIL halt_pend: got ready=%b halted=%b %h want 0 0 %h", in_ready, halted, obs,
                            mk(4'hF, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0));
      end
      flush = 1;
      tick();
      flush = 0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL halt_flush_run: got ready=%b valid=%b want 1 0", in_ready, out_valid);
      end
      in_instr = 16'hF000;
      tick();
      out_ready = 1; in_instr = 16'h4213;
      tick();
      for (int c = 0; c < 4; c++) begin
         #1;
         n_tests++;
         if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL halted[%0d]: got halted=%b ready=%b valid=%b want 1 0 0", c, halted, in_ready,
                               out_valid);
         end
         tick();
      end
      rst_n = 0;
      #1;
      n_tests++;
      if (halted !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL halt_reset: got halted=%b valid=%b want 0 0", halted, out_valid);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      in_instr = 16'h0311;
      tick();
      in_valid = 0;
      n_tests++;
      if (obs !== mk(4'h0, 16'h0, 16'h0, 16'h0, 4'h3, 1'b1)) begin
         n_fail++; $display("FAIL halt_regfile_clear: got %h want %h", obs, mk(4'h0, 16'h0, 16'h0, 16'h0, 4'h3, 1'b1));
      end
   endtask

   task automatic test_random();
      bit      exp_ready, accept;
      bundle_t nxt;
      int      idx;
      do_reset();
      for (int r = 0; r < 16; r++) begin
         m_regs[r] = '0;
         m_pend[r] = 1'b0;
      end
      m_out  = '0;
      m_mode = 0;
      wbq.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         in_valid  = ($urandom % 4) != 0;
         in_instr  = {4'($urandom_range(0, 14)), 12'($urandom)};
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 20) == 0;
         wb_en = 0; wb_addr = '0; wb_data = 16'($urandom);
         if ($urandom % 20 == 0) begin
            wb_en = 1; wb_addr = 4'd0;
         end else if (wbq.size() > 0 && $urandom % 3 == 0) begin
            idx = $urandom_range(0, wbq.size() - 1);
            wb_en = 1; wb_addr = wbq[idx];
            wbq.delete(idx);
         end
         #1;
         exp_ready = (m_mode == 0) && !m_stall(in_instr) && (!m_out.valid || out_ready) && !flush;
         n_tests++;
         if (in_ready !== exp_ready) begin
            n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b (instr %h)", cyc, in_ready, exp_ready, in_instr);
         end
         n_tests++;
         if (m_out.valid ? (obs !== m_out) : (out_valid !== 1'b0)) begin
            n_fail++; $display("FAIL rnd_bundle[%0d]: got %h want %h", cyc, obs, m_out);
         end
         accept = in_valid && exp_ready;
         nxt = m_out;
         if (flush) nxt.valid = 1'b0;
         else if (accept) nxt = m_bundle(in_instr);
         else if (m_out.valid && out_ready) nxt.valid = 1'b0;
         if (!flush && m_out.valid && out_ready && m_out.wr_en) wbq.push_back(m_out.rd);
         if (wb_en && wb_addr != 4'd0) begin
            m_pend[wb_addr] = 1'b0;
            m_regs[wb_addr] = wb_data;
         end
         if (flush && m_out.valid && m_out.wr_en) m_pend[m_out.rd] = 1'b0;
         if (accept && nxt.wr_en) m_pend[nxt.rd] = 1'b1;
         m_out = nxt;
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_raw_stall();
      test_immediates();
      test_back_to_back();
      test_flush();
      test_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
